// File: rtl/gcd_job_sequencer.sv
// Job sequencer for the subtractive GCD core: it takes operand pairs, loads A then B, waits for done and returns the result.
// Optional watchdog on the RUN phase is enabled by defining GCD_TIMEOUT_EN.
module gcd_job_sequencer #(
  parameter int WIDTH      = 16,
  parameter int MAX_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_err,
  output logic             busy,
  output logic             core_start,
  output logic [WIDTH-1:0] core_data_in,
  output logic             core_clr,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_result
);

  // Handshakes: a request moves on a rising edge with in_valid && in_ready, and a
  // response moves on a rising edge with out_valid && out_ready; while a side is
  // valid and not yet accepted, its data stays stable.

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;
  localparam logic [2:0] S_CLR    = 3'd5;

  logic [2:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] gcd_q;
  logic             core_used;
  logic             timeout_hit;

`ifdef GCD_TIMEOUT_EN
  localparam int CW = $clog2(MAX_CYCLES + 1);

  logic [CW-1:0] run_cnt;
  logic          err_q;

  // Counts RUN cycles; cleared while in LOAD_B so it starts at zero on RUN entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= '0;
    end else if (state == S_LOAD_B) begin
      run_cnt <= '0;
    end else if (state == S_RUN && !core_done) begin
      run_cnt <= run_cnt + CW'(1);
    end
  end

  assign timeout_hit = (run_cnt == CW'(MAX_CYCLES - 1));
  assign out_err     = err_q;
`else
  // MAX_CYCLES is only consumed by the watchdog; this keeps it referenced.
  if (MAX_CYCLES < 1) begin : g_max_cycles_unused
  end

  assign timeout_hit = 1'b0;
  assign out_err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      gcd_q     <= '0;
      core_used <= 1'b0;
`ifdef GCD_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q <= in_a;
            b_q <= in_b;
`ifdef GCD_TIMEOUT_EN
            err_q <= 1'b0;
`endif
            // A zero operand would never terminate in the core; answer directly.
            if (in_a == '0 || in_b == '0) begin
              gcd_q     <= in_a | in_b;
              core_used <= 1'b0;
              state     <= S_RESP;
            end else begin
              core_used <= 1'b1;
              state     <= S_LOAD_A;
            end
          end
        end
        S_LOAD_A: state <= S_LOAD_B;
        S_LOAD_B: state <= S_RUN;
        S_RUN: begin
          if (core_done) begin
            gcd_q <= core_result;
            state <= S_RESP;
          end else if (timeout_hit) begin
            gcd_q <= '0;
`ifdef GCD_TIMEOUT_EN
            err_q <= 1'b1;
`endif
            state <= S_RESP;
          end
        end
        S_RESP: begin
          if (out_ready) begin
            state <= core_used ? S_CLR : S_IDLE;
          end
        end
        S_CLR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign out_valid  = (state == S_RESP);
  assign out_gcd    = gcd_q;
  assign core_start = (state == S_LOAD_A);
  assign core_clr   = (state == S_CLR);

  always_comb begin
    core_data_in = '0;
    case (state)
      S_LOAD_A: core_data_in = a_q;
      S_LOAD_B: core_data_in = b_q;
      default:  core_data_in = '0;
    endcase
  end

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Directed bench for gcd_job_sequencer with a behavioural subtractive GCD core attached.
// Build with GCD_TIMEOUT_EN defined to exercise the watchdog path.
module tb_gcd_job_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_gcd;
  logic         out_err;
  logic         busy;
  logic         core_start;
  logic [W-1:0] core_data_in;
  logic         core_clr;
  logic         core_done;
  logic [W-1:0] core_result;

  int n_cmp  = 0;
  int n_fail = 0;
  int start_cnt = 0;
  int clr_cnt   = 0;
  logic stuck_done;
  logic [W-1:0] exp_q[$];

  gcd_job_sequencer #(.WIDTH(W), .MAX_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_gcd(out_gcd), .out_err(out_err),
    .busy(busy), .core_start(core_start), .core_data_in(core_data_in), .core_clr(core_clr),
    .core_done(core_done), .core_result(core_result)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural GCD core ----------------
  logic [W-1:0] m_a, m_b;
  logic [1:0]   m_phase;
  logic         m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a <= '0; m_b <= '0; m_phase <= 2'd0; m_done <= 1'b0;
    end else if (core_clr) begin
      m_a <= '0; m_b <= '0; m_phase <= 2'd0; m_done <= 1'b0;
    end else if (core_start) begin
      m_a <= core_data_in; m_phase <= 2'd1; m_done <= 1'b0;
    end else if (m_phase == 2'd1) begin
      m_b <= core_data_in; m_phase <= 2'd2;
    end else if (m_phase == 2'd2 && !m_done && !stuck_done) begin
      if (m_a == m_b)     m_done <= 1'b1;
      else if (m_a > m_b) m_a <= m_a - m_b;
      else                m_b <= m_b - m_a;
    end
  end

  assign core_done   = m_done;
  assign core_result = m_a;

  always @(posedge clk) begin
    if (rst_n && core_start) start_cnt++;
    if (rst_n && core_clr)   clr_cnt++;
  end

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Presents one pair for a single accept edge; returns at the negedge after it.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int max_cycles, output int n);
    n = 0;
    while (!out_valid && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check(tag, out_valid, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "simulation time limit");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n, s0, c0, got, nstart, seen_valid;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0; stuck_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_core_start", core_start, 0);
    check("rst_core_clr", core_clr, 0);
    check("rst_out_gcd", out_gcd, 0);
    check("rst_out_err", out_err, 0);
    check("rst_core_data_in", core_data_in, 0);
    rst_n = 1'b1;

    // 48,18 -> 6 through the core
    out_ready = 1'b1;
    send(16'd48, 16'd18);
    check("t1_start", core_start, 1);
    check("t1_data_a", core_data_in, 48);
    check("t1_in_ready_busy", in_ready, 0);
    check("t1_busy", busy, 1);
    @(negedge clk);
    check("t1_start_low", core_start, 0);
    check("t1_data_b", core_data_in, 18);
    wait_valid("t1_valid_timeout", 100, n);
    check("t1_gcd", out_gcd, 6);
    check("t1_err", out_err, 0);
    @(negedge clk);
    check("t1_clr", core_clr, 1);
    check("t1_valid_drop", out_valid, 0);
    @(negedge clk);
    check("t1_clr_low", core_clr, 0);
    check("t1_idle", in_ready, 1);
    check("t1_start_count", start_cnt, 1);
    check("t1_clr_count", clr_cnt, 1);

    // zero-operand bypass
    s0 = start_cnt; c0 = clr_cnt;
    send(16'd0, 16'd7);
    check("t2_valid_1cyc", out_valid, 1);
    check("t2_gcd_0_7", out_gcd, 7);
    @(negedge clk);
    check("t2_back_idle", in_ready, 1);
    check("t2_no_clr", core_clr, 0);
    send(16'd0, 16'd0);
    check("t2_valid_0_0", out_valid, 1);
    check("t2_gcd_0_0", out_gcd, 0);
    @(negedge clk);
    send(16'd5, 16'd0);
    check("t2_gcd_5_0", out_gcd, 5);
    @(negedge clk);
    check("t2_start_untouched", start_cnt, s0);
    check("t2_clr_untouched", clr_cnt, c0);

    // 35,21 -> 7 with response backpressure
    out_ready = 1'b0;
    send(16'd35, 16'd21);
    wait_valid("t3_valid_timeout", 100, n);
    check("t3_gcd", out_gcd, 7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_hold_valid", out_valid, 1);
      check("t3_hold_gcd", out_gcd, 7);
      check("t3_no_clr_yet", core_clr, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("t3_clr_after_ready", core_clr, 1);
    @(negedge clk);
    check("t3_idle", in_ready, 1);

    // back-to-back (12,8) then (17,5) with in_valid held
    exp_q.push_back(16'd4);
    exp_q.push_back(16'd1);
    got = 0; nstart = 0;
    @(negedge clk);
    in_valid = 1'b1; in_a = 16'd12; in_b = 16'd8;
    for (int i = 0; i < 300 && got < 2; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        check("t4_result", out_gcd, exp_q.pop_front());
        got++;
      end
      if (core_start) begin
        nstart++;
        if (nstart == 1) begin
          in_a = 16'd17; in_b = 16'd5;
        end else begin
          check("t4_second_after_first", got, 1);
          in_valid = 1'b0;
        end
      end
    end
    check("t4_results_seen", got, 2);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);

    // asynchronous reset during RUN of (100,75), then (9,6) -> 3
    send(16'd100, 16'd75);
    repeat (3) @(negedge clk);
    check("t5_busy_in_run", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_in_ready", in_ready, 1);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_gcd", out_gcd, 0);
    check("t5_rst_start", core_start, 0);
    check("t5_rst_clr", core_clr, 0);
    check("t5_rst_data", core_data_in, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_idle_after_rst", in_ready, 1);
    send(16'd9, 16'd6);
    wait_valid("t5_valid_timeout", 100, n);
    check("t5_gcd", out_gcd, 3);
    @(negedge clk);
    check("t5_clr", core_clr, 1);
    @(negedge clk);

    // core done stuck low
    stuck_done = 1'b1;
    send(16'd30, 16'd20);
    @(negedge clk);
    check("t6_load_b_data", core_data_in, 20);
`ifdef GCD_TIMEOUT_EN
    wait_valid("t6_valid_timeout", 100, n);
    check("t6_timeout_latency", n, 17);
    check("t6_gcd_zero", out_gcd, 0);
    check("t6_err", out_err, 1);
    @(negedge clk);
    check("t6_clr", core_clr, 1);
    stuck_done = 1'b0;
    @(negedge clk);
    check("t6_idle", in_ready, 1);
    send(16'd8, 16'd12);
    wait_valid("t6b_valid_timeout", 100, n);
    check("t6b_gcd", out_gcd, 4);
    check("t6b_err_cleared", out_err, 0);
    repeat (2) @(negedge clk);
`else
    seen_valid = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    check("t6_never_valid", seen_valid, 0);
    check("t6_still_busy", busy, 1);
    check("t6_err_tied", out_err, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    stuck_done = 1'b0;
    @(negedge clk);
    check("t6_idle_after_rst", in_ready, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gcd_job_sequencer.md
Name: gcd_job_sequencer

Overview:
- Upstream feeder and result collector for the subtractive GCD core (control unit plus datapath).
- Accepts operand pairs on a valid/ready request port and loads them into the core serially: A first, then B on the shared data bus.
- Waits for the core's done, captures the result, and returns it on a valid/ready response port.
- Bypasses the core for zero operands, which would never terminate in a subtractive GCD, and clears the core between jobs.

Parameters:
- WIDTH, 16, operand/result width in bits.
- MAX_CYCLES, 1024, watchdog limit in RUN cycles. Used only with GCD_TIMEOUT_EN.

Ports:
- clk  input  1  rising-edge clock, shared with the GCD core
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request operand pair valid
- in_ready  output  1  sequencer can accept a pair (high only in IDLE)
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- out_valid  output  1  response valid
- out_ready  input  1  consumer accepts response
- out_gcd  output  WIDTH  GCD result
- out_err  output  1  job aborted by watchdog (0 when feature compiled out)
- busy  output  1  high in any state other than IDLE
- core_start  output  1  start pulse to the GCD control unit
- core_data_in  output  WIDTH  shared operand bus into the core datapath
- core_clr  output  1  one-cycle synchronous clear returning the core to its load state
- core_done  input  1  core done (sticky until core_clr)
- core_result  input  WIDTH  core A register (valid when core_done=1)

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0 except in_ready=1. Captured operands and result clear to 0.
- Request handshake: a transfer occurs when in_valid & in_ready on a rising edge. in_a and in_b are registered at that edge.
- States: IDLE, LOAD_A, LOAD_B, RUN, RESP, CLR.
- IDLE -> on accept:
  - if A==0 or B==0: go to RESP with out_gcd = A|B (covers both-zero giving 0). No core activity.
  - else: go to LOAD_A.
- LOAD_A (1 cycle): core_start=1, core_data_in=A. Then LOAD_B.
- LOAD_B (1 cycle): core_start=0, core_data_in=B. Then RUN.
- RUN:
  - core_data_in=0.
  - On the first edge where core_done=1: capture core_result into out_gcd, go to RESP.
- RESP:
  - out_valid=1. out_gcd and out_err are held stable while out_valid=1 && out_ready=0.
  - On out_ready=1: leave RESP. Next state is CLR if the core was used, else IDLE.
- CLR (1 cycle): core_clr=1. Then IDLE.
- Latency, accept edge to out_valid:
  - bypass path: 1 cycle.
  - core path: 3 cycles + core run time.
- out_valid may assert with out_ready already high; the response completes on that edge.
- No request is accepted while busy. A new job is accepted the cycle after returning to IDLE (in_ready=1 in IDLE only).
- core_start is exactly one cycle wide per job.
- A core_done that is high on entry to RUN (stale) is impossible because CLR precedes every core job. If it occurs anyway, it is treated as a result.
- Reset mid-operation: outputs return to reset values immediately. A pending response is discarded. core_clr is not pulsed; the core's own reset/clear is system-level.

Optional Feature:
- Macro: GCD_TIMEOUT_EN.
- With the macro defined:
  - a RUN-cycle counter clears on entry to RUN.
  - if it reaches MAX_CYCLES without core_done, go to RESP with out_gcd=0 and out_err=1. The following CLR still pulses.
  - out_err=0 on all normal completions.
- Without the macro: no counter; RUN waits indefinitely; out_err is tied 0.

Test Plan:
- A=48, B=18, out_ready=1 -> core_start one cycle with data_in=48, then data_in=48? no: next cycle data_in=18. Response out_gcd=6, out_err=0, followed by a one-cycle core_clr.
- A=0, B=7 -> out_valid one cycle after accept, out_gcd=7. core_start and core_clr never assert. A=0, B=0 -> out_gcd=0.
- A=35, B=21, out_ready held low for 5 cycles after out_valid -> out_valid stays high, out_gcd=7 stable, core_clr only after the out_ready edge.
- Two back-to-back requests (12,8) then (17,5) with in_valid held high -> second accepted only after IDLE. Results 4 then 1, in order.
- rst_n pulled low during RUN of (100,75) -> all outputs 0 asynchronously, in_ready=1 after release. A new job (9,6) returns 3.
- GCD_TIMEOUT_EN, MAX_CYCLES=16, core_done stuck 0 -> out_valid 16 RUN cycles after LOAD_B with out_err=1, out_gcd=0. Without the macro, out_valid never asserts.
